recon_l2_sched: RTL

- Frame scheduler for the 4-in/8-out L2 inverse-wavelet reconstruction datapath.
- Accepts r2 beats (4 coefficients per beat) from upstream and issues them to the datapath under credit-based flow control from the downstream r1 buffer.
- Appends zero-valued flush beats at frame end so the filter history drains, then counts datapath outputs to detect frame completion.
- Tags the first and last r1 output beats of each frame.

---
 rtl/recon_l2_sched_if.sv | 31 +++
 rtl/recon_l2_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/recon_l2_sched_if.sv
// Handshake bundle between the L2 reconstruction scheduler, its upstream source,
// the datapath and the downstream r1 buffer.
interface recon_l2_sched_if #(
   parameter int INTERNAL_WIDTH = 48
);
   logic                      s_valid;
   logic                      s_ready;
   logic [INTERNAL_WIDTH-1:0] s_d0;
   logic [INTERNAL_WIDTH-1:0] s_d1;
   logic [INTERNAL_WIDTH-1:0] s_d2;
   logic [INTERNAL_WIDTH-1:0] s_d3;
   logic                      rec_valid;
   logic [INTERNAL_WIDTH-1:0] rec_d0;
   logic [INTERNAL_WIDTH-1:0] rec_d1;
   logic [INTERNAL_WIDTH-1:0] rec_d2;
   logic [INTERNAL_WIDTH-1:0] rec_d3;
   logic                      rec_dout_valid;
   logic                      credit_return;
   logic                      out_sof;
   logic                      out_eof;

   modport slave (
      input  s_valid, s_d0, s_d1, s_d2, s_d3, rec_dout_valid, credit_return,
      output s_ready, rec_valid, rec_d0, rec_d1, rec_d2, rec_d3, out_sof, out_eof
   );

   modport master (
      output s_valid, s_d0, s_d1, s_d2, s_d3, rec_dout_valid, credit_return,
      input  s_ready, rec_valid, rec_d0, rec_d1, rec_d2, rec_d3, out_sof, out_eof
   );
endinterface

// File: rtl/recon_l2_sched.sv
// Frame scheduler for the 4-in/8-out L2 inverse-wavelet datapath: credit-gated
// issue, zero flush beats at frame end, output counting and sof/eof tagging.
module recon_l2_sched #(
   parameter int INTERNAL_WIDTH = 48,
   parameter int BEATS_W        = 16,
   parameter int CREDIT_MAX     = 8,
   parameter int FLUSH_BEATS    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [BEATS_W-1:0] cfg_frame_beats,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               err_credit,
   recon_l2_sched_if.slave    bus
);
   localparam int CNT_W = BEATS_W + 2;
   localparam int CW    = $clog2(CREDIT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                    state_r;
   state_t                    state_s;
   logic [CNT_W-1:0]          n_r;
   logic [CNT_W-1:0]          in_cnt_r;
   logic [CNT_W-1:0]          flush_cnt_r;
   logic [CNT_W-1:0]          out_cnt_r;
   logic [CW-1:0]             credits_r;
   logic                      prime_skip_r;
   logic                      dp_primed_r;
   logic                      err_r;
   logic                      done_r;
   logic                      rec_valid_r;
   logic [INTERNAL_WIDTH-1:0] rec_d0_r;
   logic [INTERNAL_WIDTH-1:0] rec_d1_r;
   logic [INTERNAL_WIDTH-1:0] rec_d2_r;
   logic [INTERNAL_WIDTH-1:0] rec_d3_r;

   logic                      s_ready_s;
   logic                      accept_s;
   logic                      flush_issue_s;
   logic                      issue_s;
   logic                      ret_ok_s;
   logic                      count_en_s;
   logic                      start_frame_s;
   logic                      done_s;
   logic [CNT_W-1:0]          expected_s;
   logic [CNT_W-1:0]          out_cnt_next_s;

   assign s_ready_s      = (state_r == RUN) && (credits_r != {CW{1'b0}}) && (in_cnt_r < n_r);
   assign accept_s       = bus.s_valid && s_ready_s;
   assign flush_issue_s  = (state_r == FLUSH) && (credits_r != {CW{1'b0}});
   assign issue_s        = accept_s || flush_issue_s;
   // A return with the buffer already fully credited is dropped and flagged.
   assign ret_ok_s       = bus.credit_return && (credits_r != CW'(CREDIT_MAX));
   assign count_en_s     = (state_r != IDLE) && bus.rec_dout_valid;
   assign expected_s     = n_r + CNT_W'(FLUSH_BEATS) - {{(CNT_W-1){1'b0}}, prime_skip_r};
   assign out_cnt_next_s = out_cnt_r + {{(CNT_W-1){1'b0}}, count_en_s};

   assign busy           = (state_r != IDLE);
   assign done           = done_r;
   assign err_credit     = err_r;
   assign bus.s_ready    = s_ready_s;
   assign bus.rec_valid  = rec_valid_r;
   assign bus.rec_d0     = rec_d0_r;
   assign bus.rec_d1     = rec_d1_r;
   assign bus.rec_d2     = rec_d2_r;
   assign bus.rec_d3     = rec_d3_r;
   assign bus.out_sof    = count_en_s && (out_cnt_r == {CNT_W{1'b0}});
   assign bus.out_eof    = count_en_s && (out_cnt_r == (expected_s - CNT_W'(1)));

   // Next-state and frame-control decode.
   always_comb begin
      state_s       = state_r;
      start_frame_s = 1'b0;
      done_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (cfg_frame_beats == {BEATS_W{1'b0}}) begin
                  done_s = 1'b1;
               end else begin
                  start_frame_s = 1'b1;
                  state_s       = RUN;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (accept_s && ((in_cnt_r + CNT_W'(1)) == n_r)) begin
               state_s = FLUSH;
            end else begin
               state_s = RUN;
            end
         end
         FLUSH: begin
            if (flush_issue_s && ((flush_cnt_r + CNT_W'(1)) == CNT_W'(FLUSH_BEATS))) begin
               state_s = DRAIN;
            end else begin
               state_s = FLUSH;
            end
         end
         DRAIN: begin
            if (out_cnt_next_s >= expected_s) begin
               done_s  = 1'b1;
               state_s = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Counters, credits, issue register and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_r          <= {CNT_W{1'b0}};
         in_cnt_r     <= {CNT_W{1'b0}};
         flush_cnt_r  <= {CNT_W{1'b0}};
         out_cnt_r    <= {CNT_W{1'b0}};
         credits_r    <= CW'(CREDIT_MAX);
         prime_skip_r <= 1'b0;
         dp_primed_r  <= 1'b0;
         err_r        <= 1'b0;
         done_r       <= 1'b0;
         rec_valid_r  <= 1'b0;
         rec_d0_r     <= {INTERNAL_WIDTH{1'b0}};
         rec_d1_r     <= {INTERNAL_WIDTH{1'b0}};
         rec_d2_r     <= {INTERNAL_WIDTH{1'b0}};
         rec_d3_r     <= {INTERNAL_WIDTH{1'b0}};
      end else begin
         done_r      <= done_s;
         rec_valid_r <= issue_s;
         dp_primed_r <= dp_primed_r | issue_s;
         if (bus.credit_return && !ret_ok_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
         case ({issue_s, ret_ok_s})
            2'b10:   credits_r <= credits_r - CW'(1);
            2'b01:   credits_r <= credits_r + CW'(1);
            default: credits_r <= credits_r;
         endcase
         if (start_frame_s) begin
            n_r          <= {2'b00, cfg_frame_beats};
            prime_skip_r <= !dp_primed_r;
            in_cnt_r     <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
            out_cnt_r    <= {CNT_W{1'b0}};
         end else begin
            in_cnt_r     <= in_cnt_r + {{(CNT_W-1){1'b0}}, accept_s};
            flush_cnt_r  <= flush_cnt_r + {{(CNT_W-1){1'b0}}, flush_issue_s};
            out_cnt_r    <= out_cnt_next_s;
         end
         if (accept_s) begin
            rec_d0_r <= bus.s_d0;
            rec_d1_r <= bus.s_d1;
            rec_d2_r <= bus.s_d2;
            rec_d3_r <= bus.s_d3;
         end else if (flush_issue_s) begin
            rec_d0_r <= {INTERNAL_WIDTH{1'b0}};
            rec_d1_r <= {INTERNAL_WIDTH{1'b0}};
            rec_d2_r <= {INTERNAL_WIDTH{1'b0}};
            rec_d3_r <= {INTERNAL_WIDTH{1'b0}};
         end else begin
            rec_d0_r <= rec_d0_r;
            rec_d1_r <= rec_d1_r;
            rec_d2_r <= rec_d2_r;
            rec_d3_r <= rec_d3_r;
         end
      end
   end
endmodule
